// File: rtl/rx_header_hec_check_bluetooth_ble.sv
// BLE RX header check: recomputes the 8-bit HEC over 10 info + 8 HEC bits, flags pass/fail, forwards payload on pass.
// Optional macro HEC_ERR_CNT_EN adds a saturating hec_err_count[7:0] output (cleared only by reset).
module rx_header_hec_check_bluetooth_ble #(
  parameter int         HDR_BITS = 10,
  parameter int         HEC_BITS = 8,
  parameter logic [7:0] HEC_POLY = 8'hA7,
  parameter int         CNT_W    = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                valid_in,
  input  logic                data_in,
  input  logic [7:0]          uap_dci,
  output logic [HDR_BITS-1:0] header_out,
  output logic                header_valid,
  output logic                hec_ok,
  output logic                hec_error,
  output logic                data_out,
  output logic                valid_out,
  output logic [CNT_W-1:0]    num_after_hec,
  output logic                busy,
`ifdef HEC_ERR_CNT_EN
  output logic [7:0]          hec_err_count,
`endif
  output logic [2:0]          dbg_state
);

  // Valid-only stream, no back-pressure: a bit is taken on every clock where
  // valid_in is high; valid_out marks each forwarded bit one cycle later.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_HEC  = 3'd2,
    S_CHK  = 3'd3,
    S_PASS = 3'd4,
    S_DROP = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_en_d;
  logic [7:0] r_lfsr;
  logic [3:0] r_cnt;

  logic       w_arm;
  logic       w_abort;
  logic       w_pass;
  logic       w_fwd;
  logic       w_last_hdr;
  logic       w_last_hec;
  logic [7:0] w_lfsr_next;

  assign w_arm       = enable & ~r_en_d;
  assign w_abort     = (r_state != S_IDLE) & ~enable;
  assign w_pass      = (r_lfsr == 8'h00);
  assign w_last_hdr  = (r_cnt == 4'(HDR_BITS - 1));
  assign w_last_hec  = (r_cnt == 4'(HEC_BITS - 1));
  assign w_lfsr_next = {r_lfsr[6:0], 1'b0} ^ ((data_in ^ r_lfsr[7]) ? HEC_POLY : 8'h00);
  // The CHK cycle already holds the syndrome, so a bit arriving then is forwarded on pass.
  assign w_fwd       = (r_state == S_PASS) | ((r_state == S_CHK) & w_pass);

  assign busy      = (r_state == S_HDR) | (r_state == S_HEC) | (r_state == S_CHK);
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_arm) w_next = S_HDR;
        S_HDR:  if (valid_in && w_last_hdr) w_next = S_HEC;
        S_HEC:  if (valid_in && w_last_hec) w_next = S_CHK;
        S_CHK:  w_next = w_pass ? S_PASS : S_DROP;
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en_d        <= 1'b0;
      r_lfsr        <= 8'h00;
      r_cnt         <= 4'd0;
      header_out    <= '0;
      header_valid  <= 1'b0;
      hec_ok        <= 1'b0;
      hec_error     <= 1'b0;
      data_out      <= 1'b0;
      valid_out     <= 1'b0;
      num_after_hec <= '0;
    end else begin
      r_en_d       <= enable;
      header_valid <= 1'b0;
      valid_out    <= 1'b0;
      if (!w_abort) begin
        case (r_state)
          S_IDLE: begin
            if (w_arm) begin
              r_lfsr        <= uap_dci;
              r_cnt         <= 4'd0;
              header_out    <= '0;
              hec_ok        <= 1'b0;
              hec_error     <= 1'b0;
              num_after_hec <= '0;
            end
          end
          S_HDR: begin
            if (valid_in) begin
              header_out[r_cnt] <= data_in;
              r_lfsr            <= w_lfsr_next;
              r_cnt             <= w_last_hdr ? 4'd0 : r_cnt + 4'd1;
            end
          end
          S_HEC: begin
            if (valid_in) begin
              r_lfsr <= w_lfsr_next;
              r_cnt  <= w_last_hec ? 4'd0 : r_cnt + 4'd1;
            end
          end
          S_CHK: begin
            header_valid <= 1'b1;
            if (w_pass) hec_ok <= 1'b1;
            else        hec_error <= 1'b1;
          end
          default: ;
        endcase
        if (w_fwd) begin
          data_out  <= data_in;
          valid_out <= valid_in;
          if (valid_in && (num_after_hec != {CNT_W{1'b1}}))
            num_after_hec <= num_after_hec + 1'b1;
        end
      end
    end
  end

`ifdef HEC_ERR_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hec_err_count <= 8'h00;
    end else if (!w_abort && (r_state == S_CHK) && !w_pass && (hec_err_count != 8'hFF)) begin
      hec_err_count <= hec_err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rx_header_hec_check_bluetooth_ble.sv
// Bench for rx_header_hec_check_bluetooth_ble: directed frames plus random frames against a
// polynomial-division model of the HEC; payload stream checked through an expected queue.
module tb_rx_header_hec_check_bluetooth_ble;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        valid_in;
  logic        data_in;
  logic [7:0]  uap_dci;
  logic [9:0]  header_out;
  logic        header_valid;
  logic        hec_ok;
  logic        hec_error;
  logic        data_out;
  logic        valid_out;
  logic [13:0] num_after_hec;
  logic        busy;
  logic [2:0]  dbg_state;
`ifdef HEC_ERR_CNT_EN
  logic [7:0]  hec_err_count;
  int          exp_err_cnt = 0;
`endif

  rx_header_hec_check_bluetooth_ble dut (
    .clk           (clk),
    .reset         (rst_n),
    .enable        (enable),
    .valid_in      (valid_in),
    .data_in       (data_in),
    .uap_dci       (uap_dci),
    .header_out    (header_out),
    .header_valid  (header_valid),
    .hec_ok        (hec_ok),
    .hec_error     (hec_error),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .num_after_hec (num_after_hec),
    .busy          (busy),
`ifdef HEC_ERR_CNT_EN
    .hec_err_count (hec_err_count),
`endif
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [0:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;
  bit         last_fwd = 0;
  int         hv_cnt   = 0;
  logic [9:0] exp_hdr  = '0;
  bit         exp_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Remainder of v(x) modulo g(x)=x^8+x^7+x^5+x^2+x+1 by long division.
  function automatic logic [7:0] mod_g(input logic [25:0] v);
    logic [25:0] r;
    r = v;
    for (int i = 25; i >= 8; i--)
      if (r[i]) r = r ^ (26'h1A7 << (i - 8));
    return r[7:0];
  endfunction

  // A preloaded register equals XORing the seed into the first 8 message bits.
  function automatic logic [7:0] model_hec(input logic [7:0] seed, input logic [9:0] hdr);
    logic [9:0] m;
    for (int i = 0; i < 10; i++) m[9-i] = hdr[i];
    m = m ^ {seed, 2'b00};
    return mod_g({8'h00, m, 8'h00});
  endfunction

  function automatic logic [7:0] model_syndrome(input logic [7:0] seed, input logic [9:0] hdr,
                                                input logic [7:0] hec);
    logic [17:0] m;
    for (int i = 0; i < 10; i++) m[17-i] = hdr[i];
    for (int j = 0; j < 8; j++)  m[7-j]  = hec[7-j];
    m = m ^ {seed, 10'h000};
    return mod_g({m, 8'h00});
  endfunction

  // driver: one cycle of stimulus, then checks at the falling edge
  task automatic drive_cycle(input logic en, input logic v, input logic d, input bit fwd);
    logic [0:0] e;
    enable   = en;
    valid_in = v;
    data_in  = d;
    @(negedge clk);
    check("valid_out", valid_out, last_fwd);
    if (last_fwd && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("data_out", data_out, e);
    end
    check("header_valid", header_valid, hv_cnt == 1);
    if (hv_cnt == 1) begin
      check("header_out", header_out, exp_hdr);
      check("hec_ok", hec_ok, exp_pass);
      check("hec_error", hec_error, !exp_pass);
`ifdef HEC_ERR_CNT_EN
      if (!exp_pass && exp_err_cnt < 255) exp_err_cnt++;
      check("hec_err_count", hec_err_count, exp_err_cnt);
`endif
    end
    if (hv_cnt > 0) hv_cnt--;
    last_fwd = fwd;
    if (fwd) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [7:0] seed, input logic [9:0] hdr, input logic [7:0] hec,
                           input int npay, input bit gaps, input int abort_after, input bit rst_mid);
    logic [17:0] bits;
    bit          pass;
    bit          v;
    int          fwd_cnt;
    for (int i = 0; i < 10; i++) bits[i] = hdr[i];
    for (int j = 0; j < 8; j++)  bits[10+j] = hec[7-j];
    pass    = (model_syndrome(seed, hdr, hec) == 8'h00);
    fwd_cnt = 0;
    uap_dci = seed;
    drive_cycle(1'b0, 1'b0, 1'b0, 0);
    drive_cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), 0);
    check("busy_armed", busy, 1);
    uap_dci = 8'($urandom);
    for (int i = 0; i < 18; i++) begin
      if (gaps) drive_cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 0);
      if (i == abort_after) begin
        drive_cycle(1'b0, 1'b0, 1'b0, 0);
        check("busy_abort", busy, 0);
        repeat (4) drive_cycle(1'b0, 1'b0, 1'b0, 0);
        return;
      end
      drive_cycle(1'b1, 1'b1, bits[i], 0);
    end
    exp_hdr  = hdr;
    exp_pass = pass;
    hv_cnt   = 2;
    for (int p = 0; p < npay; p++) begin
      if (rst_mid && p == 5) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid_out", valid_out, 0);
        check("rst_hec_ok", hec_ok, 0);
        check("rst_num", num_after_hec, 0);
        check("rst_header_out", header_out, 0);
        check("rst_busy", busy, 0);
        check("rst_data_out", data_out, 0);
        @(negedge clk);
        enable   = 1'b0;
        valid_in = 1'b0;
        rst_n    = 1'b1;
        exp_q.delete();
        last_fwd = 0;
        hv_cnt   = 0;
`ifdef HEC_ERR_CNT_EN
        exp_err_cnt = 0;
`endif
        @(posedge clk);
        #1;
        drive_cycle(1'b0, 1'b0, 1'b0, 0);
        check("rst_state_busy", busy, 0);
        return;
      end
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      drive_cycle(1'b1, v, 1'($urandom_range(0, 1)), v && pass);
      if (v && pass) fwd_cnt++;
    end
    repeat (2) drive_cycle(1'b1, 1'b0, 1'b0, 0);
    check("num_after_hec", num_after_hec, pass ? fwd_cnt : 0);
    check("hec_ok_held", hec_ok, pass);
    check("hec_error_held", hec_error, !pass);
    if (!pass) begin
      // enable still high after DROP: no re-arm, nothing forwarded
      repeat (20) drive_cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), 0);
      check("no_rearm_busy", busy, 0);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 0);
    check("readback_num", num_after_hec, pass ? fwd_cnt : 0);
    check("busy_end", busy, 0);
  endtask

  initial begin
    logic [7:0] s;
    logic [9:0] h;
    logic [7:0] c;
    rst_n    = 1'b0;
    enable   = 1'b0;
    valid_in = 1'b0;
    data_in  = 1'b0;
    uap_dci  = 8'h00;
    #3;
    check("reset_header_out", header_out, 0);
    check("reset_header_valid", header_valid, 0);
    check("reset_hec_ok", hec_ok, 0);
    check("reset_hec_error", hec_error, 0);
    check("reset_valid_out", valid_out, 0);
    check("reset_num", num_after_hec, 0);
    check("reset_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive_cycle(1'b0, 1'b0, 1'b0, 0);

    check("model_hec_seed01", model_hec(8'h01, 10'h000), 8'h75);
    run_frame(8'h00, 10'h000, 8'h00, 0, 0, 99, 0);
    run_frame(8'h01, 10'h000, 8'h75, 20, 0, 99, 0);
    run_frame(8'h01, 10'h000, 8'h74, 20, 0, 99, 0);
    run_frame(8'h01, 10'h000, 8'h75, 20, 1, 99, 0);
    run_frame(8'h01, 10'h000, 8'h75, 0, 0, 6, 0);
    run_frame(8'h01, 10'h000, 8'h75, 8, 0, 99, 0);
    run_frame(8'h01, 10'h000, 8'h75, 20, 0, 99, 1);

    for (int n = 0; n < 30; n++) begin
      s = 8'($urandom);
      h = 10'($urandom);
      c = model_hec(s, h);
      if ($urandom_range(0, 2) == 0) c = c ^ (8'h01 << $urandom_range(0, 7));
      run_frame(s, h, c, $urandom_range(0, 30), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, 17) : 99, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
